// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS systolic multiply-accumulate engine with skewed A/B feed and row-by-row C drain.
// Latency: start -> first c_valid = 1 + k_len + ROWS+COLS-1 cycles when a_valid never drops.
// Backpressure: a_valid gaps become bubbles during FEED; c_ready low holds the presented C row during DRAIN.
module systolic_array_os #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int K_MAX = 256,
    localparam int KW   = $clog2(K_MAX + 1),
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic                   accumulate,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ROWS*DW-1:0]     a_data,
    input  logic [COLS*DW-1:0]     b_data,
    output logic                   c_valid,
    input  logic                   c_ready,
    output logic [COLS*ACC_W-1:0]  c_data,
    output logic [RW-1:0]          c_row,
    output logic                   c_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);
    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
    state_t state, state_n;

    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          feed_fire;
    logic          tile_go;
    logic          tile_clr;
    logic          last_beat;
    logic          flush_end;
    logic          c_fire;
    logic          ov_any;

    // skewed array edge inputs
    logic [DW-1:0] a_w  [ROWS];
    logic          av_w [ROWS];
    logic [DW-1:0] b_n  [COLS];
    logic          bv_n [COLS];

    // per-PE registered operands, valids, accumulators
    logic [DW-1:0]           a_r   [ROWS][COLS];
    logic                    av_r  [ROWS][COLS];
    logic [DW-1:0]           b_r   [ROWS][COLS];
    logic                    bv_r  [ROWS][COLS];
    logic signed [ACC_W-1:0] acc   [ROWS][COLS];
    logic                    pe_ov [ROWS][COLS];

    assign a_ready   = (state == FEED);
    assign c_valid   = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign feed_fire = a_valid & a_ready;
    assign tile_go   = (state == IDLE) & start & (k_len != '0);
    assign tile_clr  = tile_go & ~accumulate;
    assign last_beat = feed_fire & (beat_cnt == k_reg - KW'(1));
    assign flush_end = (state == FLUSH) & (flush_cnt == FW'(ROWS + COLS - 2));
    assign c_fire    = c_valid & c_ready;
    assign c_last    = c_valid & (c_row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (tile_go)          state_n = FEED;
            FEED:    if (last_beat)        state_n = FLUSH;
            FLUSH:   if (flush_end)        state_n = DRAIN;
            DRAIN:   if (c_fire && c_last) state_n = IDLE;
            default:                       state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            c_row     <= '0;
            done      <= 1'b0;
        end else begin
            done <= ((state == IDLE) & start & (k_len == '0)) | (c_fire & c_last);
            if (tile_go) begin
                k_reg    <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
                beat_cnt <= '0;
            end else if (feed_fire) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            if (state == FLUSH) begin
                flush_cnt <= flush_cnt + FW'(1);
            end else begin
                flush_cnt <= '0;
            end
            if (c_fire) begin
                c_row <= c_last ? '0 : c_row + RW'(1);
            end
        end
    end

    // Row i of A (column j of B) is delayed i (j) cycles so operands of one beat meet on the anti-diagonal.
    for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
        if (i == 0) begin : g_direct
            assign a_w[i]  = a_data[DW-1:0];
            assign av_w[i] = feed_fire;
        end else begin : g_dly
            logic [DW-1:0] sr_d [i];
            logic          sr_v [i];
            always_ff @(posedge clk) begin
                if (n_rst) begin
                    for (int k = 0; k < i; k++) begin
                        sr_d[k] <= '0;
                        sr_v[k] <= 1'b0;
                    end
                end else begin
                    sr_d[0] <= a_data[i*DW +: DW];
                    sr_v[0] <= feed_fire;
                    for (int k = 1; k < i; k++) begin
                        sr_d[k] <= sr_d[k-1];
                        sr_v[k] <= sr_v[k-1];
                    end
                end
            end
            assign a_w[i]  = sr_d[i-1];
            assign av_w[i] = sr_v[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_skew_b
        if (j == 0) begin : g_direct
            assign b_n[j]  = b_data[DW-1:0];
            assign bv_n[j] = feed_fire;
        end else begin : g_dly
            logic [DW-1:0] sr_d [j];
            logic          sr_v [j];
            always_ff @(posedge clk) begin
                if (n_rst) begin
                    for (int k = 0; k < j; k++) begin
                        sr_d[k] <= '0;
                        sr_v[k] <= 1'b0;
                    end
                end else begin
                    sr_d[0] <= b_data[j*DW +: DW];
                    sr_v[0] <= feed_fire;
                    for (int k = 1; k < j; k++) begin
                        sr_d[k] <= sr_d[k-1];
                        sr_v[k] <= sr_v[k-1];
                    end
                end
            end
            assign b_n[j]  = sr_d[j-1];
            assign bv_n[j] = sr_v[j-1];
        end
    end

    // Each PE latches its operands, then accumulates them one cycle later while forwarding east/south.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DW-1:0]           a_in;
            logic                    av_in;
            logic [DW-1:0]           b_in;
            logic                    bv_in;
            logic signed [ACC_W-1:0] prod;
            logic signed [ACC_W-1:0] sum;

            if (j == 0) begin : g_west
                assign a_in  = a_w[i];
                assign av_in = av_w[i];
            end else begin : g_inner_w
                assign a_in  = a_r[i][j-1];
                assign av_in = av_r[i][j-1];
            end
            if (i == 0) begin : g_north
                assign b_in  = b_n[j];
                assign bv_in = bv_n[j];
            end else begin : g_inner_n
                assign b_in  = b_r[i-1][j];
                assign bv_in = bv_r[i-1][j];
            end

            assign prod = ACC_W'($signed(a_r[i][j])) * ACC_W'($signed(b_r[i][j]));
            assign sum  = acc[i][j] + prod;
            assign pe_ov[i][j] = av_r[i][j] & bv_r[i][j]
                               & (acc[i][j][ACC_W-1] == prod[ACC_W-1])
                               & (sum[ACC_W-1] != acc[i][j][ACC_W-1]);

            always_ff @(posedge clk) begin
                if (n_rst) begin
                    a_r[i][j]  <= '0;
                    av_r[i][j] <= 1'b0;
                    b_r[i][j]  <= '0;
                    bv_r[i][j] <= 1'b0;
                    acc[i][j]  <= '0;
                end else begin
                    a_r[i][j]  <= a_in;
                    av_r[i][j] <= av_in;
                    b_r[i][j]  <= b_in;
                    bv_r[i][j] <= bv_in;
                    if (tile_clr) begin
                        acc[i][j] <= '0;
                    end else if (av_r[i][j] && bv_r[i][j]) begin
                        acc[i][j] <= sum;
                    end
                end
            end
        end
    end

    always_comb begin
        ov_any = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                ov_any = ov_any | pe_ov[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            overflow <= 1'b0;
        end else if (tile_clr) begin
            overflow <= 1'b0;
        end else if (ov_any) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        c_data = '0;
        if (c_valid) begin
            for (int j = 0; j < COLS; j++) begin
                c_data[j*ACC_W +: ACC_W] = acc[c_row][j];
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_os.sv
// Self-checking bench for systolic_array_os: directed tiles plus randomized tiles against a
// plain matrix-arithmetic model of C with 24-bit wrap and overflow tracking.
module tb_systolic_array_os;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
    localparam int K_MAX = 256;

    logic                  clk;
    logic                  n_rst;
    logic                  start;
    logic [8:0]            k_len;
    logic                  accumulate;
    logic                  a_valid;
    logic                  a_ready;
    logic [ROWS*DW-1:0]    a_data;
    logic [COLS*DW-1:0]    b_data;
    logic                  c_valid;
    logic                  c_ready;
    logic [COLS*ACC_W-1:0] c_data;
    logic [1:0]            c_row;
    logic                  c_last;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    systolic_array_os #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .k_len(k_len), .accumulate(accumulate),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_row(c_row),
        .c_last(c_last), .busy(busy), .done(done), .overflow(overflow)
    );

    int     vectors = 0;
    int     errors  = 0;
    int     cyc     = 0;
    int     exp_row = 0;
    int     am [ROWS][K_MAX];
    int     bm [K_MAX][COLS];
    longint mc [ROWS][COLS];
    bit     exp_ov = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrap24(input longint v);
        longint m;
        m = v & 64'hFFFFFF;
        if (m >= 64'sd8388608) m = m - 64'sd16777216;
        return m;
    endfunction

    // C (+)= A*B computed directly; each PE adds in increasing k order.
    task automatic model_tile(input int k, input bit accum);
        longint s;
        if (!accum) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) mc[i][j] = 0;
            exp_ov = 0;
        end
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    s = mc[i][j] + longint'(am[i][kk]) * longint'(bm[kk][j]);
                    if (s > 64'sd8388607 || s < -64'sd8388608) exp_ov = 1;
                    mc[i][j] = wrap24(s);
                end
    endtask

    // Every cycle a C row is presented, it must match the model at the expected row.
    always @(negedge clk) begin
        if (!n_rst && c_valid) begin
            chk("c_row", longint'(c_row), longint'(exp_row));
            chk("c_last", longint'(c_last), longint'(exp_row == ROWS - 1));
            for (int j = 0; j < COLS; j++)
                chk("c_data", longint'($signed(c_data[j*ACC_W +: ACC_W])), mc[exp_row][j]);
            if (c_ready) exp_row = (exp_row + 1) % ROWS;
        end
    end

    task automatic load_t1();
        for (int kk = 0; kk < 4; kk++)
            for (int i = 0; i < ROWS; i++) am[i][kk] = (i == kk) ? 1 : 0;
        for (int kk = 0; kk < 4; kk++)
            for (int j = 0; j < COLS; j++) bm[kk][j] = 4 * kk + j + 1;
    endtask

    task automatic load_rand(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < ROWS; i++) am[i][kk] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < COLS; j++) bm[kk][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_a_ready"}, longint'(a_ready), 0);
        chk({tag, "_c_valid"}, longint'(c_valid), 0);
        chk({tag, "_c_last"}, longint'(c_last), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_overflow"}, longint'(overflow), 0);
        chk({tag, "_c_data_nz"}, longint'(c_data != '0), 0);
        chk({tag, "_c_row"}, longint'(c_row), 0);
    endtask

    // vmode: 0 always valid, 1 bubble every other FEED cycle (starting with a bubble), 2 random.
    // rmode: 0 c_ready high, 1 c_ready low 5 cycles on row 2, 2 random.
    task automatic run_tile(input int k, input bit accum, input int vmode, input int rmode,
                            input int exp_feed);
        int keff;
        int beat;
        int guard;
        int feed_cyc;
        int s_cyc;
        int lat;
        int stall;
        bit got_last;
        bit hs_row1;
        keff = (k > K_MAX) ? K_MAX : k;
        beat = 0; guard = 0; feed_cyc = 0; lat = -1; stall = 0; got_last = 0;
        model_tile(keff, accum);
        exp_row = 0;
        start = 1; k_len = 9'(k); accumulate = accum;
        @(posedge clk); #1;
        s_cyc = cyc;
        start = 0;
        while (beat < keff && guard < 4000) begin
            case (vmode)
                0:       a_valid = 1;
                1:       a_valid = (feed_cyc % 2 == 1);
                default: a_valid = ($urandom_range(0, 2) != 0);
            endcase
            for (int i = 0; i < ROWS; i++) a_data[i*DW +: DW] = am[i][beat][DW-1:0];
            for (int j = 0; j < COLS; j++) b_data[j*DW +: DW] = bm[beat][j][DW-1:0];
            @(negedge clk);
            if (a_ready) feed_cyc++;
            if (a_valid && a_ready) beat++;
            @(posedge clk); #1;
            guard++;
        end
        a_valid = 0;
        if (guard >= 4000) chk("feed_timeout", beat, keff);
        if (exp_feed >= 0) chk("feed_cycles", feed_cyc, exp_feed);
        c_ready = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        guard = 0;
        while (!got_last && guard < 2000) begin
            @(negedge clk);
            if (guard == 0) begin
                chk("a_ready_after_last_beat", longint'(a_ready), 0);
                chk("busy_after_last_beat", longint'(busy), 1);
            end
            if (c_valid && lat < 0) lat = cyc - s_cyc;
            if (c_valid && c_ready && c_last) got_last = 1;
            hs_row1 = c_valid && c_ready && (c_row == 2'd1);
            @(posedge clk); #1;
            guard++;
            if (rmode == 1 && hs_row1) stall = 5;
            if (stall > 0) begin
                c_ready = 0;
                stall--;
            end else begin
                c_ready = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
        if (!got_last) chk("drain_timeout", 0, 1);
        if (vmode == 0) chk("latency", lat, keff + ROWS + COLS - 1);
        @(negedge clk);
        chk("done_pulse", longint'(done), 1);
        chk("busy_after_tile", longint'(busy), 0);
        chk("overflow", longint'(overflow), longint'(exp_ov));
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_single", longint'(done), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_zero_k();
        start = 1; k_len = 0; accumulate = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("zk_done", longint'(done), 1);
        chk("zk_busy", longint'(busy), 0);
        chk("zk_c_valid", longint'(c_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zk_done_single", longint'(done), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_rst = 1; start = 0; k_len = 0; accumulate = 0; a_valid = 0;
        a_data = '0; b_data = '0; c_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        n_rst = 0;
        @(posedge clk); #1;

        load_t1();
        run_tile(4, 0, 0, 0, 4);
        chk("pin_t1_c23", mc[2][3], 12);
        run_tile(4, 0, 1, 0, 8);
        run_tile(4, 1, 0, 0, 4);
        chk("pin_acc_c33", mc[3][3], 32);
        run_tile(4, 0, 0, 0, 4);
        chk("pin_clr_c00", mc[0][0], 1);
        run_tile(4, 0, 0, 1, 4);
        run_zero_k();
        run_tile(4, 1, 0, 2, 4);
        chk("pin_zk_acc_c10", mc[1][0], 10);

        for (int kk = 0; kk < K_MAX; kk++) begin
            for (int i = 0; i < ROWS; i++) am[i][kk] = -128;
            for (int j = 0; j < COLS; j++) bm[kk][j] = -128;
        end
        run_tile(256, 0, 0, 0, 256);
        chk("pin_big_c12", mc[1][2], 4194304);
        chk("big_overflow_clear", longint'(overflow), 0);
        run_tile(256, 1, 0, 0, 256);
        chk("pin_wrap_c30", mc[3][0], -8388608);
        chk("wrap_overflow_set", longint'(overflow), 1);
        run_zero_k();
        chk("overflow_sticky", longint'(overflow), 1);

        load_t1();
        start = 1; k_len = 4; accumulate = 1;
        @(posedge clk); #1;
        start = 0; a_valid = 1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < ROWS; i++) a_data[i*DW +: DW] = am[i][b][DW-1:0];
            for (int j = 0; j < COLS; j++) b_data[j*DW +: DW] = bm[b][j][DW-1:0];
            @(posedge clk); #1;
        end
        a_valid = 0; n_rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset("abort");
        @(posedge clk); #1;
        n_rst = 0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) mc[i][j] = 0;
        exp_ov = 0;
        @(posedge clk); #1;
        run_tile(4, 1, 0, 0, 4);
        chk("pin_abort_c11", mc[1][1], 6);

        for (int t = 0; t < 8; t++) begin
            int k;
            k = int'($urandom_range(1, 20));
            load_rand(k);
            run_tile(k, bit'($urandom_range(0, 1)), 2, 2, -1);
        end
        load_rand(1);
        run_tile(1, 0, 0, 0, 1);
        load_rand(K_MAX);
        run_tile(300, 0, 2, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
